i2c_bit_engine: RTL

Bit-level I2C master engine sitting directly downstream of the Avalon-MM register front end. It consumes single-cycle command pulses (start, stop, write, read_ack, read_nack) together with txdata and clk_div. It drives open-drain SCL/SDA, returns rxdata, and reports done pulses plus busy/ack status to the front end's status/interrupt logic. Clock stretching is supported; multi-master arbitration is not.

---
 rtl/i2c_bit_engine_pkg.sv | 51 +++++
 rtl/i2c_bit_engine_half.sv | 37 +++
 rtl/i2c_bit_engine.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/i2c_bit_engine_pkg.sv
// Shared definitions for the I2C bit-level master engine.
//   state_e          : sequencer states
//   cmd_e            : decoded command, already reduced by priority
//   MIN_DIV_DEFAULT  : floor for the half-period length
//   *_HALVES         : number of half SCL periods per command
//   pick_cmd()       : priority reduction start > stop > write > read_ack > read_nack
//   last_half()      : index of the final half for a given command state
package i2c_bit_engine_pkg;

  localparam int unsigned MIN_DIV_DEFAULT = 2;

  localparam logic [4:0] START_HALVES = 5'd4;
  localparam logic [4:0] STOP_HALVES  = 5'd3;
  localparam logic [4:0] BYTE_HALVES  = 5'd18;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_STOP,
    ST_WRITE,
    ST_READ
  } state_e;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_START,
    CMD_STOP,
    CMD_WRITE,
    CMD_READ_ACK,
    CMD_READ_NACK
  } cmd_e;

  function automatic cmd_e pick_cmd(input logic start, input logic stop, input logic write,
                                    input logic read_ack, input logic read_nack);
    if (start)     return CMD_START;
    if (stop)      return CMD_STOP;
    if (write)     return CMD_WRITE;
    if (read_ack)  return CMD_READ_ACK;
    if (read_nack) return CMD_READ_NACK;
    return CMD_NONE;
  endfunction

  function automatic logic [4:0] last_half(input state_e st);
    case (st)
      ST_START: return START_HALVES - 5'd1;
      ST_STOP:  return STOP_HALVES - 5'd1;
      default:  return BYTE_HALVES - 5'd1;
    endcase
  endfunction

endpackage

// File: rtl/i2c_bit_engine_half.sv
// Half-period timer for the I2C bit engine.
//   clk, reset_n : system clock, async active-low reset
//   div_i        : half-period length D in clk cycles (already floored)
//   enable_i     : counter runs while a command is in progress, else parks at 0
//   hold_i       : SCL released but held low by a slave; counter freezes
//   half_end_o   : high in the last cycle of each half
module i2c_half_timer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] div_i,
  input  logic        enable_i,
  input  logic        hold_i,
  output logic        half_end_o
);

  logic [15:0] cnt_q, cnt_d;
  logic        at_end;

  assign at_end     = (cnt_q == div_i - 16'd1);
  assign half_end_o = enable_i && !hold_i && at_end;

  // NOTE: cnt_d gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d = cnt_q;
    if (!enable_i)    cnt_d = '0;
    else if (hold_i)  cnt_d = cnt_q;
    else if (at_end)  cnt_d = '0;
    else              cnt_d = cnt_q + 16'd1;
  end

  // NOTE: sequential state uses non-blocking assignments with async active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/i2c_bit_engine.sv
// Bit-level I2C master engine (single master, clock stretching supported).
//   clk, reset_n                        : system clock, async active-low reset
//   clk_div[15:0]                       : half SCL period in clk cycles, latched on accept
//   txdata[7:0]                         : byte to send, latched on write accept
//   start/stop/write/read_ack/read_nack : single-cycle command pulses, accepted only when idle
//   sda_i, scl_i                        : synchronised bus levels
//   rxdata[7:0]                         : received byte, updated with rx_done
//   buzy, ack_fail                      : command in progress / last write saw NACK
//   *_done                              : single-cycle completion pulses
//   sda_o, scl_o                        : open-drain drive, 1 = release
module i2c_bit_engine
  import i2c_bit_engine_pkg::*;
#(
  parameter int unsigned MIN_DIV = MIN_DIV_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] clk_div,
  input  logic [7:0]  txdata,
  input  logic        start,
  input  logic        stop,
  input  logic        write,
  input  logic        read_ack,
  input  logic        read_nack,
  input  logic        sda_i,
  input  logic        scl_i,
  output logic [7:0]  rxdata,
  output logic        buzy,
  output logic        ack_fail,
  output logic        rx_done,
  output logic        tx_done,
  output logic        start_done,
  output logic        stop_done,
  output logic        sda_o,
  output logic        scl_o
);

  state_e      state_q;
  logic [4:0]  half_q;
  logic [15:0] div_q;
  logic [7:0]  tx_q, rx_shift_q, rxdata_q;
  logic        read_ack_q, ack_fail_q, buzy_q;
  logic        scl_q, sda_q;
  logic        rx_done_q, tx_done_q, start_done_q, stop_done_q;

  cmd_e        cmd;
  logic [15:0] div_eff;
  logic        half_end;
  logic [4:0]  half_nxt;
  logic [3:0]  nxt_bit;
  logic [2:0]  tx_idx;
  logic        byte_bit;

  assign cmd      = pick_cmd(start, stop, write, read_ack, read_nack);
  assign div_eff  = (clk_div < 16'(MIN_DIV)) ? 16'(MIN_DIV) : clk_div;
  assign half_nxt = half_q + 5'd1;
  assign nxt_bit  = half_nxt[4:1];
  assign tx_idx   = 3'd7 - nxt_bit[2:0];

  // SDA level for the low half that is about to begin: data bits MSB first,
  // then the ninth (ACK) bit is released on write and driven by read_ack on read.
  always_comb begin
    byte_bit = 1'b1;
    if (state_q == ST_WRITE) byte_bit = (nxt_bit == 4'd8) ? 1'b1 : tx_q[tx_idx];
    else if (nxt_bit == 4'd8) byte_bit = ~read_ack_q;
  end

  // Stretch only matters in a half where we release SCL and the bus is still low.
  i2c_half_timer u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .div_i      (div_q),
    .enable_i   (buzy_q),
    .hold_i     (scl_q && !scl_i),
    .half_end_o (half_end)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      half_q       <= '0;
      div_q        <= 16'(MIN_DIV);
      tx_q         <= '0;
      rx_shift_q   <= '0;
      rxdata_q     <= '0;
      read_ack_q   <= 1'b0;
      ack_fail_q   <= 1'b0;
      buzy_q       <= 1'b0;
      scl_q        <= 1'b1;
      sda_q        <= 1'b1;
      rx_done_q    <= 1'b0;
      tx_done_q    <= 1'b0;
      start_done_q <= 1'b0;
      stop_done_q  <= 1'b0;
    end else begin
      rx_done_q    <= 1'b0;
      tx_done_q    <= 1'b0;
      start_done_q <= 1'b0;
      stop_done_q  <= 1'b0;

      if (state_q == ST_IDLE) begin
        if (cmd != CMD_NONE) begin
          div_q  <= div_eff;
          half_q <= '0;
          buzy_q <= 1'b1;
        end
        // Each branch sets the bus levels for half 0 of the accepted command.
        case (cmd)
          CMD_START: begin
            state_q    <= ST_START;
            sda_q      <= 1'b1;
            ack_fail_q <= 1'b0;
          end
          CMD_STOP: begin
            state_q <= ST_STOP;
            scl_q   <= 1'b0;
            sda_q   <= 1'b0;
          end
          CMD_WRITE: begin
            state_q <= ST_WRITE;
            tx_q    <= txdata;
            scl_q   <= 1'b0;
            sda_q   <= txdata[7];
          end
          CMD_READ_ACK, CMD_READ_NACK: begin
            state_q    <= ST_READ;
            read_ack_q <= (cmd == CMD_READ_ACK);
            scl_q      <= 1'b0;
            sda_q      <= 1'b1;
          end
          default: ;
        endcase
      end else if (half_end) begin
        // Odd halves of a byte are SCL-high; sample at their last cycle.
        if ((state_q == ST_WRITE || state_q == ST_READ) && half_q[0]) begin
          if (half_q[4:1] == 4'd8) begin
            if (state_q == ST_WRITE) ack_fail_q <= sda_i;
          end else if (state_q == ST_READ) begin
            rx_shift_q <= {rx_shift_q[6:0], sda_i};
          end
        end

        if (half_q == last_half(state_q)) begin
          state_q <= ST_IDLE;
          buzy_q  <= 1'b0;
          case (state_q)
            ST_START: start_done_q <= 1'b1;
            ST_STOP:  stop_done_q  <= 1'b1;
            ST_WRITE: tx_done_q    <= 1'b1;
            default: begin
              rx_done_q <= 1'b1;
              rxdata_q  <= rx_shift_q;
            end
          endcase
        end else begin
          half_q <= half_nxt;
          case (state_q)
            ST_START: begin
              if (half_nxt == 5'd1)      scl_q <= 1'b1;
              else if (half_nxt == 5'd2) sda_q <= 1'b0;
              else                       scl_q <= 1'b0;
            end
            ST_STOP: begin
              if (half_nxt == 5'd1) scl_q <= 1'b1;
              else                  sda_q <= 1'b1;
            end
            default: begin
              // SDA moves only together with SCL falling into a low half.
              if (!half_nxt[0]) begin
                scl_q <= 1'b0;
                sda_q <= byte_bit;
              end else begin
                scl_q <= 1'b1;
              end
            end
          endcase
        end
      end
    end
  end

  assign rxdata     = rxdata_q;
  assign buzy       = buzy_q;
  assign ack_fail   = ack_fail_q;
  assign rx_done    = rx_done_q;
  assign tx_done    = tx_done_q;
  assign start_done = start_done_q;
  assign stop_done  = stop_done_q;
  assign sda_o      = sda_q;
  assign scl_o      = scl_q;

endmodule
